// File: rtl/axi_switch_pkg.sv
// Shared AXI switch definitions: response-channel modes and the ID tracker entry layout.
package axi_switch_pkg;

  localparam int unsigned LAST_MODE_R = 1;
  localparam int unsigned LAST_MODE_B = 0;

  // Entry widths for the default 2-master / MAX_OUT=4 switch configuration
  localparam int unsigned ENTRY_LOG_M = 1;
  localparam int unsigned ENTRY_CNT_W = 3;

  typedef struct packed {
    logic [ENTRY_LOG_M-1:0] mst;
    logic [ENTRY_CNT_W-1:0] cnt;
  } id_entry_t;

endpackage

// File: rtl/id_track_bank.sv
// One slave's per-ID outstanding table: owner master and count per ID,
// plus a running total so busy does not need a wide OR across entries.
module id_track_bank #(
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned LOG_M    = 1,
  parameter int unsigned MAX_OUT  = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_wr_en,
  input  logic [ID_WIDTH-1:0] i_wr_id,
  input  logic [LOG_M-1:0]    i_wr_src,
  output logic                o_wr_rdy,
  input  logic [ID_WIDTH-1:0] i_lk_id,
  output logic [LOG_M-1:0]    o_lk_mst,
  output logic                o_lk_vld,
  input  logic                i_ret_en,
  input  logic                i_err_clr,
  output logic                o_err,
  output logic                o_busy
);

  localparam int unsigned DEPTH = 2 ** ID_WIDTH;
  localparam int unsigned TOT_W = CNT_W + ID_WIDTH;

  // Same packed layout as axi_switch_pkg::id_entry_t, sized from this instance's parameters
  typedef struct packed {
    logic [LOG_M-1:0] mst;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  entry_t           r_tab [DEPTH];
  logic [TOT_W-1:0] r_total;
  logic             r_err;

  entry_t           w_wr_e;
  entry_t           w_lk_e;
  logic             w_inc;
  logic             w_dec;
  logic             w_orphan;
  logic [DEPTH-1:0] w_inc_vec;
  logic [DEPTH-1:0] w_dec_vec;

  always_comb begin
    w_wr_e    = r_tab[i_wr_id];
    w_lk_e    = r_tab[i_lk_id];
    o_wr_rdy  = (w_wr_e.cnt < CNT_W'(MAX_OUT)) &&
                ((w_wr_e.cnt == '0) || (w_wr_e.mst == i_wr_src));
    o_lk_mst  = w_lk_e.mst;
    o_lk_vld  = (w_lk_e.cnt != '0);
    w_inc     = i_wr_en && o_wr_rdy;
    w_dec     = i_ret_en && o_lk_vld;
    w_orphan  = i_ret_en && !o_lk_vld;
    w_inc_vec = DEPTH'(w_inc) << i_wr_id;
    w_dec_vec = DEPTH'(w_dec) << i_lk_id;
  end

  // Accept and retire on the same entry cancel out; owner is left untouched
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_tab[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (w_inc_vec[k] && !w_dec_vec[k]) begin
          r_tab[k].cnt <= r_tab[k].cnt + CNT_W'(1);
          r_tab[k].mst <= i_wr_src;
        end else if (w_dec_vec[k] && !w_inc_vec[k]) begin
          r_tab[k].cnt <= r_tab[k].cnt - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_total <= '0;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_total <= r_total + TOT_W'(1);
        2'b01:   r_total <= r_total - TOT_W'(1);
        default: r_total <= r_total;
      endcase
    end
  end

  // A new orphan response takes priority over a clear in the same cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (w_orphan) begin
      r_err <= 1'b1;
    end else if (i_err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign o_err  = r_err;
  assign o_busy = (r_total != '0);

endmodule

// File: rtl/resp_id_tracker.sv
// Per-slave, per-ID outstanding-transaction tracker for one AXI response channel (R or B):
// routes each slave's response to its master, enforces same-ID ordering and flags orphans.
module resp_id_tracker import axi_switch_pkg::*; #(
  parameter int unsigned M         = 2,
  parameter int unsigned N         = 2,
  parameter int unsigned ID_WIDTH  = 4,
  parameter int unsigned MAX_OUT   = 4,
  parameter int unsigned LAST_MODE = LAST_MODE_R,
  parameter int unsigned LOG_M     = (M > 1) ? $clog2(M) : 1,
  parameter int unsigned LOG_N     = (N > 1) ? $clog2(N) : 1,
  parameter int unsigned CNT_W     = $clog2(MAX_OUT + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                reqVld_i,
  output logic                reqRdy_o,
  input  logic [ID_WIDTH-1:0] reqId_i,
  input  logic [LOG_M-1:0]    reqSrc_i,
  input  logic [LOG_N-1:0]    reqDst_i,
  input  logic [N-1:0]        rspVld_i,
  input  logic [N-1:0]        rspRdy_i,
  input  logic [N-1:0]        rspLast_i,
  input  logic [ID_WIDTH-1:0] rspId_i [N],
  output logic [LOG_M-1:0]    rspTarget_o [N],
  output logic [N-1:0]        rspTargetVld_o,
  output logic [N-1:0]        busy_o,
  output logic [N-1:0]        err_o,
  input  logic                errClr_i
);

  localparam logic LAST_IGNORED = (LAST_MODE == LAST_MODE_B);

  logic [N-1:0] w_sel;
  logic [N-1:0] w_wr_en;
  logic [N-1:0] w_bank_rdy;
  logic [N-1:0] w_ret;

  for (genvar n = 0; n < N; n++) begin : g_bank
    assign w_sel[n]   = (reqDst_i == LOG_N'(n));
    assign w_wr_en[n] = reqVld_i && w_sel[n];
    assign w_ret[n]   = rspVld_i[n] && rspRdy_i[n] && (rspLast_i[n] || LAST_IGNORED);

    id_track_bank #(
      .ID_WIDTH (ID_WIDTH),
      .LOG_M    (LOG_M),
      .MAX_OUT  (MAX_OUT),
      .CNT_W    (CNT_W)
    ) u_bank (
      .clk       (clk),
      .rstn      (rstn),
      .i_wr_en   (w_wr_en[n]),
      .i_wr_id   (reqId_i),
      .i_wr_src  (reqSrc_i),
      .o_wr_rdy  (w_bank_rdy[n]),
      .i_lk_id   (rspId_i[n]),
      .o_lk_mst  (rspTarget_o[n]),
      .o_lk_vld  (rspTargetVld_o[n]),
      .i_ret_en  (w_ret[n]),
      .i_err_clr (errClr_i),
      .o_err     (err_o[n]),
      .o_busy    (busy_o[n])
    );
  end

  // Only the addressed bank's readiness matters; an out-of-range slave index is never ready
  assign reqRdy_o = |(w_sel & w_bank_rdy);

endmodule

// File: tb/tb_resp_id_tracker.sv
// Scoreboard bench for resp_id_tracker: an R-mode and a B-mode instance share request stimulus.
module tb_resp_id_tracker;
  import axi_switch_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic       reqVld;
  logic [3:0] reqId;
  logic [0:0] reqSrc;
  logic [0:0] reqDst;
  logic [1:0] rspVld, rspRdy, rspLast, bRspVld;
  logic [3:0] rspId [2];
  logic       errClr;

  logic       reqRdy, bReqRdy;
  logic [0:0] tgt [2];
  logic [0:0] bTgt [2];
  logic [1:0] tvld, busy, err, bTvld, bBusy, bErr;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int    cyc;
    int    kind;
    int    idx;
    int    val;
    string name;
  } exp_t;
  exp_t q[$];

  resp_id_tracker #(
    .M(2), .N(2), .ID_WIDTH(4), .MAX_OUT(4), .LAST_MODE(LAST_MODE_R)
  ) dut (
    .clk(clk), .rstn(rstn), .reqVld_i(reqVld), .reqRdy_o(reqRdy), .reqId_i(reqId),
    .reqSrc_i(reqSrc), .reqDst_i(reqDst), .rspVld_i(rspVld), .rspRdy_i(rspRdy),
    .rspLast_i(rspLast), .rspId_i(rspId), .rspTarget_o(tgt), .rspTargetVld_o(tvld),
    .busy_o(busy), .err_o(err), .errClr_i(errClr)
  );

  resp_id_tracker #(
    .M(2), .N(2), .ID_WIDTH(4), .MAX_OUT(4), .LAST_MODE(LAST_MODE_B)
  ) dut_b (
    .clk(clk), .rstn(rstn), .reqVld_i(reqVld), .reqRdy_o(bReqRdy), .reqId_i(reqId),
    .reqSrc_i(reqSrc), .reqDst_i(reqDst), .rspVld_i(bRspVld), .rspRdy_i(rspRdy),
    .rspLast_i(rspLast), .rspId_i(rspId), .rspTarget_o(bTgt), .rspTargetVld_o(bTvld),
    .busy_o(bBusy), .err_o(bErr), .errClr_i(errClr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(input exp_t e);
    case (e.kind)
      0:       return int'(reqRdy);
      1:       return int'(tvld[e.idx]);
      2:       return int'(tgt[e.idx]);
      3:       return int'(busy);
      4:       return int'(err);
      5:       return int'(bReqRdy);
      default: return int'(bTvld[e.idx]);
    endcase
  endfunction

  // Monitor: pops every expectation due this cycle and compares away from the clock edge
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      int   a;
      e = q.pop_front();
      a = actual(e);
      checks++;
      if (a != e.val || e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, a, e.val, e.cyc);
      end
    end
  end

  task automatic chk(input int kind, input int idx, input int val, input string name);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reqVld = 1'b0; rspVld = '0; bRspVld = '0; rspLast = '0; errClr = 1'b0;
  endtask

  task automatic req(input int dst, input int id, input int src);
    reqVld = 1'b1; reqDst = 1'(dst); reqId = 4'(id); reqSrc = 1'(src);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; idle(); rspRdy = 2'b11; reqDst = '0; reqId = '0; reqSrc = '0;
    rspId[0] = '0; rspId[1] = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // reset / idle
    tick();
    chk(0,0,1,"rst_rdy"); chk(1,0,0,"rst_tvld0"); chk(1,1,0,"rst_tvld1");
    chk(3,0,0,"rst_busy"); chk(4,0,0,"rst_err"); chk(2,0,0,"rst_tgt0");

    // basic R transaction on slave 1, id 3, master 1
    tick(); req(1,3,1); rspId[1] = 4'd3;
    chk(0,0,1,"r_acc_rdy"); chk(1,1,0,"r_no_bypass");
    tick(); idle();
    chk(2,1,1,"r_tgt"); chk(1,1,1,"r_tvld"); chk(3,0,2,"r_busy");
    for (int i = 0; i < 2; i++) begin
      tick(); rspVld[1] = 1'b1; rspLast[1] = 1'b0; chk(1,1,1,"r_beat_tvld");
    end
    tick(); rspVld[1] = 1'b1; rspLast[1] = 1'b1; chk(1,1,1,"r_last_tvld");
    tick(); idle(); chk(1,1,0,"r_done_tvld"); chk(3,0,0,"r_done_busy");

    // saturation on slave 0, id 5
    for (int i = 0; i < 4; i++) begin
      tick(); req(0,5,0); chk(0,0,1,"sat_rdy"); chk(5,0,1,"sat_b_rdy");
    end
    tick(); chk(0,0,0,"sat_full"); chk(5,0,0,"sat_b_full");
    tick(); reqVld = 1'b0; bRspVld[0] = 1'b1; rspId[0] = 4'd5; rspLast[0] = 1'b0;
    chk(5,0,0,"b_ret_cycle_rdy");
    tick(); bRspVld = '0;
    chk(5,0,1,"b_ret_rdy"); chk(0,0,0,"r_still_full"); chk(1,0,1,"sat_tvld0"); chk(2,0,0,"sat_tgt0");
    tick(); rspVld[0] = 1'b1; rspLast[0] = 1'b1;
    tick(); rspVld[0] = 1'b0; chk(0,0,1,"r_ret_rdy");
    for (int i = 0; i < 3; i++) begin
      tick(); rspVld[0] = 1'b1; bRspVld[0] = 1'b1; rspLast[0] = 1'b1;
    end
    tick(); idle();
    chk(1,0,0,"sat_clean_tvld"); chk(6,0,0,"sat_clean_b_tvld"); chk(3,0,0,"sat_clean_busy");
    chk(4,0,0,"no_err_yet");

    // same-ID ordering: master 1 blocked while master 0 owns slave 0 / id 2
    tick(); req(0,2,0); chk(0,0,1,"ord_first_rdy");
    tick(); req(0,2,1); chk(0,0,0,"ord_blk");
    tick(); chk(0,0,0,"ord_blk2");
    tick(); rspVld[0] = 1'b1; bRspVld[0] = 1'b1; rspLast[0] = 1'b1; rspId[0] = 4'd2;
    chk(0,0,0,"ord_same_cyc"); chk(5,0,0,"ord_b_same_cyc");
    tick(); rspVld = '0; bRspVld = '0; rspLast = '0;
    chk(0,0,1,"ord_acc"); chk(5,0,1,"ord_b_acc");
    tick(); reqVld = 1'b0; chk(2,0,1,"ord_tgt"); chk(1,0,1,"ord_tvld");
    tick(); rspVld[0] = 1'b1; bRspVld[0] = 1'b1; rspLast[0] = 1'b1;
    tick(); idle(); chk(1,0,0,"ord_clean");

    // orphan response on slave 1, id 7
    tick(); rspVld[1] = 1'b1; rspLast[1] = 1'b1; rspId[1] = 4'd7; chk(4,0,0,"err_pre");
    tick(); idle(); chk(4,0,2,"err_set"); chk(1,1,0,"err_cnt_zero"); chk(3,0,0,"err_busy");
    tick(); chk(4,0,2,"err_sticky");
    tick(); errClr = 1'b1; chk(4,0,2,"err_clr_cycle");
    tick(); errClr = 1'b0; chk(4,0,0,"err_cleared");
    tick(); errClr = 1'b1; rspVld[1] = 1'b1; rspLast[1] = 1'b1;
    tick(); idle(); chk(4,0,2,"err_set_wins");
    tick(); errClr = 1'b1;
    tick(); idle(); chk(4,0,0,"err_clr2");

    // accept and retire on the same entry in one cycle (slave 0, id 9, cnt 2)
    tick(); req(0,9,1); rspId[0] = 4'd9;
    tick();
    tick(); rspVld[0] = 1'b1; rspLast[0] = 1'b1; chk(0,0,1,"sc_rdy"); chk(1,0,1,"sc_tvld");
    tick(); idle(); rspVld[0] = 1'b1; rspLast[0] = 1'b1; chk(1,0,1,"sc_cnt2");
    tick(); idle(); chk(1,0,1,"sc_cnt1");
    tick(); rspVld[0] = 1'b1; rspLast[0] = 1'b1;
    tick(); idle(); chk(1,0,0,"sc_cnt0"); chk(3,0,0,"sc_busy"); chk(4,0,0,"sc_noerr");

    // reset in the middle of a burst
    tick(); req(1,4,1);
    tick();
    tick(); req(0,1,0);
    tick(); idle(); rspVld[1] = 1'b1; rspId[1] = 4'd4; rspLast[1] = 1'b0; rspId[0] = 4'd1;
    chk(1,1,1,"burst_tvld"); chk(1,0,1,"burst_tvld0"); chk(3,0,3,"burst_busy");
    tick(); rstn = 1'b0; reqDst = 1'b1; reqId = 4'd4; reqSrc = 1'b0;
    chk(0,0,1,"rst_mid_rdy"); chk(1,1,0,"rst_mid_tvld1"); chk(1,0,0,"rst_mid_tvld0");
    chk(3,0,0,"rst_mid_busy"); chk(4,0,0,"rst_mid_err"); chk(2,1,0,"rst_mid_tgt1");
    tick(); rstn = 1'b1; rspVld[1] = 1'b1; rspLast[1] = 1'b1;
    tick(); idle(); chk(4,0,2,"orphan_after_rst");

    tick(); tick();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
